furv_mem_arbiter: RTL

Shares one single-ported memory between the furv core's instruction-fetch path and its load/store path. Each side presents a request and holds it until a one-cycle response pulse. The arbiter grants requests round-robin, drives the memory port with a variable-latency ready handshake, and returns read data. A per-transfer wait-limit counter turns a hung memory into an error response instead of a core stall.

---
 rtl/furv_pkg.sv | 27 ++
 rtl/furv_mem_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/furv_pkg.sv
// Shared types and constants for the furv memory arbiter.
package furv_pkg;

  localparam int unsigned XLEN = 32;

  // RV32I "addi x0, x0, 0": harmless data to hand back when a transfer is aborted.
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

  // Memory-port request payload captured at grant time.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/furv_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction
// fetch (if_*) and load/store (d_*). A wait-limit counter converts a hung
// memory into an error response carrying ERR_DATA.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   if_req/if_addr          fetch request (held until if_valid)
//   if_valid/if_rdata       fetch completion pulse and instruction
//   d_req/d_we/d_addr/d_wdata  load/store request (held until d_valid)
//   d_valid/d_rdata         data completion pulse and load data
//   m_req/m_we/m_addr/m_wdata  memory request (held until m_ready)
//   m_ready/m_rdata         memory handshake and read data
//   err                     pulse alongside valid of an aborted transfer
module furv_mem_arbiter
  import furv_pkg::*;
#(
  parameter int unsigned     WAIT_LIMIT = 16,
  parameter logic [XLEN-1:0] ERR_DATA   = NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_valid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_ready,
  input  logic [XLEN-1:0] m_rdata,
  output logic            err
);

  localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);

  state_e   state;
  owner_e   owner;
  owner_e   last_grant;
  logic [CW-1:0] wait_cnt;
  mem_req_t mreq;
  owner_e   grant_c;

  // On a tie the side that did not win last time gets the memory.
  function automatic owner_e pick(input logic ifr, input logic dr, input owner_e last);
    return (ifr && dr) ? ((last == OWN_IF) ? OWN_D : OWN_IF) : (dr ? OWN_D : OWN_IF);
  endfunction

  assign grant_c = pick(if_req, d_req, last_grant);

  assign m_we    = mreq.we;
  assign m_addr  = mreq.addr;
  assign m_wdata = mreq.wdata;

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      wait_cnt   <= '0;
      mreq       <= '0;
      m_req      <= 1'b0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      err        <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            if (grant_c == OWN_D) begin
              mreq <= '{we: d_we, addr: d_addr, wdata: d_wdata};
            end else begin
              // Fetch leaves the write-data register untouched.
              mreq.we   <= 1'b0;
              mreq.addr <= if_addr;
            end
            owner      <= grant_c;
            last_grant <= grant_c;
            wait_cnt   <= '0;
            m_req      <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (m_ready) begin
            m_req <= 1'b0;
            if (owner == OWN_IF) begin
              if_rdata <= m_rdata;
              if_valid <= 1'b1;
            end else begin
              if (!mreq.we) d_rdata <= m_rdata;
              d_valid <= 1'b1;
            end
            state <= RESP;
          end else if (wait_cnt == CW'(WAIT_LIMIT - 1)) begin
            m_req <= 1'b0;
            err   <= 1'b1;
            if (owner == OWN_IF) begin
              if_rdata <= ERR_DATA;
              if_valid <= 1'b1;
            end else begin
              if (!mreq.we) d_rdata <= ERR_DATA;
              d_valid <= 1'b1;
            end
            state <= RESP;
          end else if (wait_cnt != CW'(WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          if_valid <= 1'b0;
          d_valid  <= 1'b0;
          err      <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
